uart_rx_pkt_ctrl: RTL and testbench
===================================

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the packet start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, meaning the maximum payload bytes per packet (range 1..16).
REQ-003 SHALL have parameter TIMEOUT, default 50000, meaning the maximum number of idle clock cycles allowed between bytes inside a packet.
REQ-004 CLK  input  1  single clock, all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 RX_DATA  input  8  byte from the UART receiver, valid when RX_DONE=1.
REQ-007 RX_DONE  input  1  one-cycle pulse per received byte.
REQ-008 PKT_DATA  output  8  payload byte of the validated packet.
REQ-009 PKT_VALID  output  1  PKT_DATA is valid.
REQ-010 PKT_READY  input  1  downstream accepts PKT_DATA.
REQ-011 PKT_LAST  output  1  the current PKT_DATA is the final payload byte.
REQ-012 BUSY  output  1  high in every state except HUNT.
REQ-013 ERR_CSUM, ERR_LEN, ERR_TIMEOUT, OVERRUN  output  1 each  one-cycle error pulses.
REQ-014 PKT_CNT  output  8  count of packets delivered, wrapping 255->0.

Function
REQ-015 Packet format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CSUM, where CSUM is the 8-bit XOR of LEN and all payload bytes.
REQ-016 FSM SHALL have states HUNT, LEN, PAYLOAD, CHECK and DRAIN; only RX_DONE=1 cycles consume a byte.
REQ-017 In HUNT, byte==SYNC_BYTE -> LEN; any other byte SHALL be discarded silently.
REQ-018 In LEN, a LEN value of 0 or greater than MAX_LEN SHALL pulse ERR_LEN in the next cycle and go to HUNT; otherwise the FSM stores LEN, seeds the XOR accumulator with LEN, and goes to PAYLOAD.
REQ-019 In PAYLOAD, each byte SHALL be written to buffer[wr_idx] and XORed into the accumulator; after the LEN-th byte the FSM goes to CHECK.
REQ-020 In CHECK, a CSUM byte equal to the accumulator SHALL go to DRAIN with PKT_VALID=1 in the next cycle; a mismatch SHALL pulse ERR_CSUM in the next cycle and go to HUNT.
REQ-021 In DRAIN, PKT_DATA SHALL equal buffer[rd_idx]; a transfer occurs when PKT_VALID&PKT_READY, and then rd_idx increments.
REQ-022 PKT_LAST SHALL be high exactly when rd_idx==LEN-1 and PKT_VALID=1.
REQ-023 On the last transfer, PKT_CNT SHALL increment and the FSM SHALL go to HUNT with PKT_VALID=0 in the next cycle.
REQ-024 PKT_VALID and PKT_DATA SHALL remain stable while PKT_READY=0.
REQ-025 An RX_DONE during DRAIN SHALL drop the byte and pulse OVERRUN in the next cycle; draining continues unaffected.
REQ-026 The timeout counter SHALL clear on entering LEN and on every RX_DONE in LEN, PAYLOAD or CHECK, and SHALL be held at zero in HUNT and DRAIN.
REQ-027 When the timeout counter reaches TIMEOUT-1 without RX_DONE, the FSM SHALL pulse ERR_TIMEOUT in the next cycle and go to HUNT.
REQ-028 If RX_DONE coincides with timeout expiry, the byte SHALL win and no ERR_TIMEOUT is generated.
REQ-029 At most one error pulse SHALL be asserted per cycle.
REQ-030 A received byte equal to SYNC_BYTE outside HUNT SHALL be treated as data; there is no resynchronisation mid-packet.

Reset
REQ-031 While RST=1, state SHALL be HUNT and PKT_DATA=0, PKT_VALID=0, PKT_LAST=0, BUSY=0, all error pulses=0, PKT_CNT=0, and all indices, accumulator and timeout counter SHALL be 0.
REQ-032 Reset asserted mid-packet or mid-drain SHALL abort it immediately, with no error pulse; buffer contents need not be cleared.

Structure
REQ-033 Package uart_pkg SHALL hold the state encoding, the SYNC_BYTE and MAX_LEN defaults, and the 16-entry depth constant.
REQ-034 The payload store SHALL be a sub-module pkt_buf: 16x8, synchronous write, combinational read, no reset.

Verification
REQ-035 Send A5 03 11 22 33 03 with PKT_READY=1 -> PKT_DATA 11,22,33 on consecutive cycles, PKT_LAST on 33, and PKT_CNT=1.
REQ-036 Send A5 02 AA 55 00 -> ERR_CSUM pulse (expected CSUM FD), no PKT_VALID, and the FSM back in HUNT with BUSY=0.
REQ-037 Send A5 00 and then A5 11 -> two ERR_LEN pulses and PKT_CNT unchanged.
REQ-038 Send A5 04 01 and then idle for 50000 cycles -> ERR_TIMEOUT exactly once, after which a good packet is accepted normally.
REQ-039 Send a good 2-byte packet with PKT_READY=0 for 20 cycles while a 0x7E byte arrives -> OVERRUN pulse, and PKT_DATA held stable, with both bytes delivered after READY rises.
REQ-040 Assert RST during PAYLOAD -> all outputs go to reset values asynchronously, and the next A5 01 42 43 delivers 0x42.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared constants for the UART packet receive controller.
// Rev 1.0 -- initial release.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         MAX_LEN_DEF   = 16;
  localparam int         BUF_DEPTH     = 16;
  localparam int         BUF_AW        = $clog2(BUF_DEPTH);

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pkt_buf.sv
`default_nettype none
// pkt_buf: 16x8 payload store, synchronous write, combinational read, no reset.
// Rev 1.0 -- initial release.
module pkt_buf
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// uart_rx_pkt_ctrl: frames SYNC/LEN/payload/CSUM packets from a UART byte stream,
// validates them and drains the payload over a valid/ready interface. Rev 1.0.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_LEN   = MAX_LEN_DEF,
  parameter int         TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       busy,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       overrun,
  output logic [7:0] pkt_cnt
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [4:0]        len;
  logic [BUF_AW-1:0] wr_idx;
  logic [BUF_AW-1:0] rd_idx;
  logic [7:0]        acc;
  logic [TW-1:0]     tmo_cnt;
  logic [7:0]        rd_byte;
  logic              in_rx_state;
  logic              tmo_hit;
  logic              len_bad;
  logic              wr_last;
  logic              rd_last;
  logic              xfer;
  logic              buf_we;

  pkt_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx),
    .wdata (rx_data),
    .raddr (rd_idx),
    .rdata (rd_byte)
  );

  assign in_rx_state = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);
  assign len_bad     = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));
  assign wr_last     = ({1'b0, wr_idx} == (len - 5'd1));
  assign rd_last     = ({1'b0, rd_idx} == (len - 5'd1));
  assign buf_we      = rx_done && (state == ST_PAYLOAD);

  assign busy      = (state != ST_HUNT);
  assign pkt_valid = (state == ST_DRAIN);
  assign pkt_data  = pkt_valid ? rd_byte : 8'h00;
  assign pkt_last  = pkt_valid && rd_last;
  assign xfer      = pkt_valid && pkt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      len         <= 5'd0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      acc         <= 8'h00;
      tmo_cnt     <= '0;
      pkt_cnt     <= 8'h00;
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_csum    <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;

      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (!in_rx_state || rx_done) begin
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        tmo_cnt     <= '0;
        err_timeout <= 1'b1;
        state       <= ST_HUNT;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      case (state)
        ST_HUNT: begin
          if (rx_done && (rx_data == SYNC_BYTE)) state <= ST_LEN;
        end
        ST_LEN: begin
          if (rx_done) begin
            if (len_bad) begin
              err_len <= 1'b1;
              state   <= ST_HUNT;
            end else begin
              len    <= rx_data[4:0];
              acc    <= rx_data;
              wr_idx <= '0;
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_done) begin
            acc <= acc ^ rx_data;
            if (wr_last) state <= ST_CHECK;
            else         wr_idx <= wr_idx + BUF_AW'(1);
          end
        end
        ST_CHECK: begin
          if (rx_done) begin
            if (rx_data == acc) begin
              rd_idx <= '0;
              state  <= ST_DRAIN;
            end else begin
              err_csum <= 1'b1;
              state    <= ST_HUNT;
            end
          end
        end
        ST_DRAIN: begin
          if (rx_done) overrun <= 1'b1;
          if (xfer) begin
            if (rd_last) begin
              rd_idx  <= '0;
              pkt_cnt <= pkt_cnt + 8'd1;
              state   <= ST_HUNT;
            end else begin
              rd_idx <= rd_idx + BUF_AW'(1);
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_uart_rx_pkt_ctrl: directed scenarios plus randomized packets against a queue model.
module tb_uart_rx_pkt_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 16;
  localparam int         TMO  = 50000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       pkt_ready = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_last;
  logic       busy;
  logic       err_csum;
  logic       err_len;
  logic       err_timeout;
  logic       overrun;
  logic [7:0] pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE (SYNC),
    .MAX_LEN   (MAXL),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_last    (pkt_last),
    .busy        (busy),
    .err_csum    (err_csum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .overrun     (overrun),
    .pkt_cnt     (pkt_cnt)
  );

  // Output monitor: delivered bytes, pulse counts and hold-while-stalled tracking.
  logic [8:0] got_q[$];
  int         n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0, n_unstable = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!pkt_valid || pkt_data !== prev_data)) n_unstable++;
      stall_prev = pkt_valid && !pkt_ready;
      prev_data  = pkt_data;
      if (pkt_valid && pkt_ready) got_q.push_back({pkt_last, pkt_data});
      n_csum += int'(err_csum);
      n_len  += int'(err_len);
      n_tmo  += int'(err_timeout);
      n_ovr  += int'(overrun);
      if (int'(err_csum) + int'(err_len) + int'(err_timeout) + int'(overrun) > 1) n_multi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input int gap);
    sync();
    foreach (q[i]) begin
      rx_data = q[i];
      rx_done = 1'b1;
      sync();
      rx_done = 1'b0;
      repeat (gap) sync();
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      pkt_ready = 1'($urandom_range(0, 1));
      sync();
      n++;
    end
    chk("idle_bound", 32'(n < bound), 32'd1);
  endtask

  logic [7:0] q[$];
  logic [7:0] one[$];
  logic [8:0] exp_q[$];
  logic [7:0] cs;
  logic [7:0] b;
  logic [7:0] exp_cnt;
  int         base, base_got, base_csum, base_len, base_tmo;
  int         exp_csum_n, exp_len_n, len, kind;

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid_last", {30'd0, pkt_valid, pkt_last}, 32'd0);
    chk("rst_data", 32'(pkt_data), 32'd0);
    chk("rst_errs", {28'd0, err_csum, err_len, err_timeout, overrun}, 32'd0);
    chk("rst_cnt", 32'(pkt_cnt), 32'd0);
    sync();
    rst = 1'b0;

    // Good 3-byte packet, always ready
    pkt_ready = 1'b1;
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_bytes(q, 0);
    sample();
    chk("g3_valid0", 32'(pkt_valid), 32'd1);
    chk("g3_data0", {23'd0, pkt_last, pkt_data}, {23'd0, 1'b0, 8'h11});
    sample();
    chk("g3_data1", {23'd0, pkt_last, pkt_data}, {23'd0, 1'b0, 8'h22});
    sample();
    chk("g3_data2", {23'd0, pkt_last, pkt_data}, {23'd0, 1'b1, 8'h33});
    sample();
    chk("g3_end_valid", 32'(pkt_valid), 32'd0);
    chk("g3_cnt", 32'(pkt_cnt), 32'd1);
    chk("g3_busy", 32'(busy), 32'd0);

    // Checksum error: 02^AA^55 = FD, 00 sent
    q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_bytes(q, 0);
    sample();
    chk("cs_err", 32'(err_csum), 32'd1);
    chk("cs_valid", 32'(pkt_valid), 32'd0);
    chk("cs_busy", 32'(busy), 32'd0);
    sample();
    chk("cs_pulse_width", 32'(err_csum), 32'd0);

    // Length errors at both bounds
    base = n_len;
    q = '{8'hA5, 8'h00};
    send_bytes(q, 0);
    sample();
    chk("len0_err", 32'(err_len), 32'd1);
    q = '{8'hA5, 8'h11};
    send_bytes(q, 0);
    sample();
    chk("len17_err", 32'(err_len), 32'd1);
    chk("len_count", 32'(n_len - base), 32'd2);
    chk("len_cnt_hold", 32'(pkt_cnt), 32'd1);

    // Inter-byte timeout
    base = n_tmo;
    q = '{8'hA5, 8'h04, 8'h01};
    send_bytes(q, 0);
    repeat (TMO - 1) sync();
    chk("tmo_early", 32'(n_tmo - base), 32'd0);
    chk("tmo_busy_before", 32'(busy), 32'd1);
    repeat (10) sync();
    chk("tmo_once", 32'(n_tmo - base), 32'd1);
    chk("tmo_busy_after", 32'(busy), 32'd0);
    q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    send_bytes(q, 0);
    sample();
    chk("tmo_next_pkt", {23'd0, pkt_valid, pkt_last, pkt_data}, {23'd0, 2'b11, 8'h5A});
    sample();
    chk("tmo_next_cnt", 32'(pkt_cnt), 32'd2);

    // Overrun while stalled
    pkt_ready = 1'b0;
    base = n_ovr;
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    send_bytes(q, 0);
    sample();
    chk("ovr_valid", {23'd0, pkt_valid, pkt_last, pkt_data}, {23'd0, 2'b10, 8'h10});
    one = '{8'h7E};
    send_bytes(one, 0);
    sample();
    chk("ovr_pulse", 32'(overrun), 32'd1);
    repeat (18) sync();
    chk("ovr_hold", {23'd0, pkt_valid, pkt_last, pkt_data}, {23'd0, 2'b10, 8'h10});
    chk("ovr_stable", 32'(n_unstable), 32'd0);
    base_got = got_q.size();
    pkt_ready = 1'b1;
    repeat (4) sync();
    chk("ovr_count", 32'(n_ovr - base), 32'd1);
    chk("ovr_ndeliv", 32'(got_q.size() - base_got), 32'd2);
    if (got_q.size() >= base_got + 2) begin
      chk("ovr_b0", 32'(got_q[base_got]), {23'd0, 1'b0, 8'h10});
      chk("ovr_b1", 32'(got_q[base_got + 1]), {23'd0, 1'b1, 8'h20});
    end
    chk("ovr_cnt", 32'(pkt_cnt), 32'd3);

    // Asynchronous reset mid-payload
    q = '{8'hA5, 8'h04, 8'h01};
    send_bytes(q, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(pkt_cnt), 32'd0);
    chk("arst_outs", {20'd0, pkt_valid, pkt_last, pkt_data, err_csum, err_len}, 32'd0);
    sync();
    rst = 1'b0;
    q = '{8'hA5, 8'h01, 8'h42, 8'h43};
    send_bytes(q, 0);
    sample();
    chk("arst_deliver", {23'd0, pkt_valid, pkt_last, pkt_data}, {23'd0, 2'b11, 8'h42});
    sample();
    chk("arst_cnt_after", 32'(pkt_cnt), 32'd1);

    // Randomized packets: noise, bad lengths, bad checksums, good packets with random ready
    exp_cnt    = 8'd1;
    base_got   = got_q.size();
    base_csum  = n_csum;
    base_len   = n_len;
    base_tmo   = n_tmo;
    exp_csum_n = 0;
    exp_len_n  = 0;
    exp_q.delete();
    for (int p = 0; p < 40; p++) begin
      q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        q.push_back(b);
      end
      kind = $urandom_range(0, 7);
      q.push_back(SYNC);
      if (kind == 0) begin
        len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXL + 1, 255);
        q.push_back(8'(len));
        exp_len_n++;
      end else begin
        len = $urandom_range(1, MAXL);
        q.push_back(8'(len));
        cs = 8'(len);
        for (int i = 0; i < len; i++) begin
          b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
          q.push_back(b);
          cs = cs ^ b;
          if (kind != 1) exp_q.push_back({1'(i == len - 1), b});
        end
        if (kind == 1) begin
          cs = cs ^ 8'($urandom_range(1, 255));
          exp_csum_n++;
        end else begin
          exp_cnt = exp_cnt + 8'd1;
        end
        q.push_back(cs);
      end
      send_bytes(q, $urandom_range(0, 2));
      wait_idle(300);
    end
    repeat (3) sync();
    chk("rnd_ndeliv", 32'(got_q.size() - base_got), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (base_got + i < got_q.size())
        chk($sformatf("rnd_byte%0d", i), 32'(got_q[base_got + i]), 32'(exp_q[i]));
    end
    chk("rnd_csum_errs", 32'(n_csum - base_csum), 32'(exp_csum_n));
    chk("rnd_len_errs", 32'(n_len - base_len), 32'(exp_len_n));
    chk("rnd_no_tmo", 32'(n_tmo - base_tmo), 32'd0);
    chk("rnd_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    chk("one_err_per_cycle", 32'(n_multi), 32'd0);
    chk("hold_while_stalled", 32'(n_unstable), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
